// File: rtl/timestamp_splitter.sv
// Splits records of frame beats plus a multi-beat timestamp (header or trailer) into
// a pass-through frame stream and a FIFO-buffered timestamp stream, flagging tlast faults.
module timestamp_splitter #(
  parameter int DATA_WIDTH         = 8,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int TIMESTAMP_WIDTH    = 72,
  parameter int TS_POSITION        = 0,
  parameter int TS_FIFO_DEPTH      = 4,
  parameter int ERR_COUNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
  input  logic                          s_axis_frame_length_tvalid,
  output logic                          s_axis_frame_length_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [TIMESTAMP_WIDTH-1:0]    m_axis_timestamp_tdata,
  output logic                          m_axis_timestamp_tvalid,
  input  logic                          m_axis_timestamp_tready,
  output logic                          err_pulse,
  output logic [ERR_COUNT_WIDTH-1:0]    err_count
);

  localparam int TS_BEATS = TIMESTAMP_WIDTH / DATA_WIDTH;
  localparam int TSC_W    = (TS_BEATS > 1) ? $clog2(TS_BEATS) : 1;
  localparam int PTR_W    = $clog2(TS_FIFO_DEPTH);
  localparam bit HDR_MODE = (TS_POSITION == 1);
  localparam logic [TSC_W-1:0] TS_LAST = TSC_W'(TS_BEATS - 1);

  typedef enum logic [2:0] {IDLE, HDR_TS, FRAME, TRL_TS, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [FRAME_LENGTH_WIDTH-1:0]  len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [TSC_W-1:0]               ts_cnt_q, ts_cnt_d;
  logic [TIMESTAMP_WIDTH-1:0]     ts_q, ts_d, ts_merged, push_data;
  logic                           err_det, err_pulse_q;
  logic [ERR_COUNT_WIDTH-1:0]     err_count_q;
  logic                           s_tready_c, len_tready_c, m_tvalid_c, m_tlast_c;
  logic [DATA_WIDTH-1:0]          m_tdata_c;
  logic                           frame_last, ts_last, push, pop;

  logic [TIMESTAMP_WIDTH-1:0]     mem_q [TS_FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]                 count_q;
  logic                           fifo_full, fifo_empty;

  assign fifo_full  = (count_q == (PTR_W+1)'(TS_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && m_axis_timestamp_tready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    ts_cnt_d     = ts_cnt_q;
    ts_d         = ts_q;
    err_det      = 1'b0;
    push         = 1'b0;
    s_tready_c   = 1'b0;
    len_tready_c = 1'b0;
    m_tvalid_c   = 1'b0;
    m_tlast_c    = 1'b0;
    m_tdata_c    = '0;
    ts_merged    = ts_q | (TIMESTAMP_WIDTH'(s_axis_tdata) << (ts_cnt_q * DATA_WIDTH));
    push_data    = ts_merged;
    frame_last   = (beat_cnt_q == len_q - FRAME_LENGTH_WIDTH'(1));
    ts_last      = (ts_cnt_q == TS_LAST);
    unique case (state_q)
      IDLE: begin
        len_tready_c = 1'b1;
        if (s_axis_frame_length_tvalid) begin
          len_d      = s_axis_frame_length_tdata;
          beat_cnt_d = '0;
          ts_cnt_d   = '0;
          ts_d       = '0;
          if (s_axis_frame_length_tdata == '0) begin
            err_det = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = HDR_MODE ? HDR_TS : FRAME;
          end
        end
      end
      HDR_TS, TRL_TS: begin
        // Only the final trailer beat pushes, so only it waits for FIFO space.
        s_tready_c = !(state_q == TRL_TS && ts_last && fifo_full);
        if (s_axis_tvalid && s_tready_c) begin
          ts_d     = ts_merged;
          ts_cnt_d = ts_cnt_q + TSC_W'(1);
          if (!ts_last) begin
            if (s_axis_tlast) begin
              err_det = 1'b1;
              state_d = IDLE;
            end
          end else if (state_q == HDR_TS) begin
            err_det = s_axis_tlast;
            state_d = s_axis_tlast ? IDLE : FRAME;
          end else begin
            push    = 1'b1;
            err_det = !s_axis_tlast;
            state_d = s_axis_tlast ? IDLE : DRAIN;
          end
        end
      end
      FRAME: begin
        m_tvalid_c = s_axis_tvalid;
        m_tdata_c  = s_axis_tdata;
        m_tlast_c  = frame_last || s_axis_tlast;
        s_tready_c = m_axis_tready && !(HDR_MODE && frame_last && fifo_full);
        if (s_axis_tvalid && s_tready_c) begin
          beat_cnt_d = beat_cnt_q + FRAME_LENGTH_WIDTH'(1);
          if (!frame_last) begin
            if (s_axis_tlast) begin
              err_det = 1'b1;
              state_d = IDLE;
            end
          end else if (HDR_MODE) begin
            push      = 1'b1;
            push_data = ts_q;
            err_det   = !s_axis_tlast;
            state_d   = s_axis_tlast ? IDLE : DRAIN;
          end else begin
            ts_cnt_d = '0;
            err_det  = s_axis_tlast;
            state_d  = s_axis_tlast ? IDLE : TRL_TS;
          end
        end
      end
      DRAIN: begin
        s_tready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      ts_cnt_q    <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      ts_cnt_q    <= ts_cnt_d;
      err_pulse_q <= err_det;
      if (err_det && err_count_q != '1) err_count_q <= err_count_q + ERR_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    len_q <= len_d;
    ts_q  <= ts_d;
  end

  // Timestamp FIFO: pointers and occupancy are reset, storage is not.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign s_axis_tready              = rstn && s_tready_c;
  assign s_axis_frame_length_tready = rstn && len_tready_c;
  assign m_axis_tvalid              = rstn && m_tvalid_c;
  assign m_axis_tlast               = rstn && m_tlast_c;
  assign m_axis_tdata               = m_tdata_c;
  assign m_axis_timestamp_tvalid    = rstn && !fifo_empty;
  assign m_axis_timestamp_tdata     = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign err_pulse                  = err_pulse_q;
  assign err_count                  = err_count_q;

endmodule

// File: tb/tb_timestamp_splitter.sv
// Bench for timestamp_splitter: trailer-mode (index 0) and header-mode (index 1)
// instances, scoreboard queues filled by the stimulus and drained by output monitors.
module tb_timestamp_splitter;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int TW = 72;
  localparam int EW = 16;

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata [2];
  logic          s_tvalid [2];
  logic          s_tready [2];
  logic          s_tlast [2];
  logic [LW-1:0] len_tdata [2];
  logic          len_tvalid [2];
  logic          len_tready [2];
  logic [DW-1:0] m_tdata [2];
  logic          m_tvalid [2];
  logic          m_tready [2];
  logic          m_tlast [2];
  logic [TW-1:0] m_ts_tdata [2];
  logic          m_ts_tvalid [2];
  logic          m_ts_tready [2];
  logic          err_pulse [2];
  logic [EW-1:0] err_count [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    timestamp_splitter #(
      .DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(LW), .TIMESTAMP_WIDTH(TW),
      .TS_POSITION(g), .TS_FIFO_DEPTH(4), .ERR_COUNT_WIDTH(EW)
    ) u_dut (
      .clk(clk), .rstn(rstn),
      .s_axis_tdata(s_tdata[g]), .s_axis_tvalid(s_tvalid[g]),
      .s_axis_tready(s_tready[g]), .s_axis_tlast(s_tlast[g]),
      .s_axis_frame_length_tdata(len_tdata[g]),
      .s_axis_frame_length_tvalid(len_tvalid[g]),
      .s_axis_frame_length_tready(len_tready[g]),
      .m_axis_tdata(m_tdata[g]), .m_axis_tvalid(m_tvalid[g]),
      .m_axis_tready(m_tready[g]), .m_axis_tlast(m_tlast[g]),
      .m_axis_timestamp_tdata(m_ts_tdata[g]),
      .m_axis_timestamp_tvalid(m_ts_tvalid[g]),
      .m_axis_timestamp_tready(m_ts_tready[g]),
      .err_pulse(err_pulse[g]), .err_count(err_count[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int pulses [2];
  int exp_err [2];
  bit rand_bp = 1'b0;

  beat_t         fr_q0 [$];
  beat_t         fr_q1 [$];
  logic [TW-1:0] ts_q0 [$];
  logic [TW-1:0] ts_q1 [$];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic maybe_gap();
    if (rand_bp) idle($urandom_range(0, 2));
  endtask

  task automatic exp_beat(int d, logic [DW-1:0] data, logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    if (d == 0) fr_q0.push_back(b); else fr_q1.push_back(b);
  endtask

  task automatic exp_ts(int d, logic [TW-1:0] t);
    if (d == 0) ts_q0.push_back(t); else ts_q1.push_back(t);
  endtask

  task automatic send_len(int d, logic [LW-1:0] len);
    int n = 0;
    logic hs = 1'b0;
    len_tdata[d] = len;
    len_tvalid[d] = 1'b1;
    while (!hs && n < 500) begin
      @(negedge clk); hs = len_tready[d]; n++;
      @(posedge clk); #1;
    end
    if (!hs) chk($sformatf("len_timeout[%0d]", d), hs, 1'b1);
    len_tvalid[d] = 1'b0;
  endtask

  task automatic send_beat(int d, logic [DW-1:0] data, logic last);
    int n = 0;
    logic hs = 1'b0;
    s_tdata[d] = data;
    s_tlast[d] = last;
    s_tvalid[d] = 1'b1;
    while (!hs && n < 500) begin
      @(negedge clk); hs = s_tready[d]; n++;
      @(posedge clk); #1;
    end
    if (!hs) chk($sformatf("beat_timeout[%0d]", d), hs, 1'b1);
    s_tvalid[d] = 1'b0;
    s_tlast[d] = 1'b0;
  endtask

  // Well-formed record: scoreboard entries pushed first, then the beats in record order.
  task automatic good_record(int d, logic [DW-1:0] fr [$], logic [DW-1:0] tsb [9]);
    int L = fr.size();
    logic [TW-1:0] t;
    for (int i = 0; i < L; i++) exp_beat(d, fr[i], i == L - 1);
    for (int k = 0; k < 9; k++) t[k*DW +: DW] = tsb[k];
    exp_ts(d, t);
    send_len(d, LW'(L));
    maybe_gap();
    if (d == 1) for (int k = 0; k < 9; k++) begin send_beat(d, tsb[k], 1'b0); maybe_gap(); end
    for (int i = 0; i < L; i++) begin
      if (d == 1 && i == L - 1 && ts_q1.size() == 1)
        chk("hdr_ts_before_frame_end", m_ts_tvalid[1], 1'b0);
      send_beat(d, fr[i], d == 1 && i == L - 1);
      maybe_gap();
    end
    if (d == 0) for (int k = 0; k < 9; k++) begin send_beat(d, tsb[k], k == 8); maybe_gap(); end
  endtask

  task automatic rand_record(int d, int L);
    logic [DW-1:0] fr [$];
    logic [DW-1:0] tsb [9];
    for (int i = 0; i < L; i++) fr.push_back(DW'($urandom));
    for (int k = 0; k < 9; k++) tsb[k] = DW'($urandom);
    good_record(d, fr, tsb);
  endtask

  task automatic chk_idle_outputs(string tag, logic len_rdy);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_s_tready[%0d]", tag, d), s_tready[d], 1'b0);
      chk($sformatf("%s_len_tready[%0d]", tag, d), len_tready[d], len_rdy);
      chk($sformatf("%s_m_tvalid[%0d]", tag, d), m_tvalid[d], 1'b0);
      chk($sformatf("%s_m_tlast[%0d]", tag, d), m_tlast[d], 1'b0);
      chk($sformatf("%s_ts_tvalid[%0d]", tag, d), m_ts_tvalid[d], 1'b0);
      chk($sformatf("%s_err_pulse[%0d]", tag, d), err_pulse[d], 1'b0);
      chk($sformatf("%s_err_count[%0d]", tag, d), err_count[d], 16'd0);
    end
  endtask

  task automatic chk_errors(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_err_count[%0d]", tag, d), err_count[d], exp_err[d]);
      chk($sformatf("%s_err_pulses[%0d]", tag, d), pulses[d], exp_err[d]);
    end
  endtask

  task automatic mon(int d);
    beat_t b;
    logic [TW-1:0] t;
    int sz;
    if (m_tvalid[d] && m_tready[d]) begin
      sz = (d == 0) ? fr_q0.size() : fr_q1.size();
      chk($sformatf("frame_beat_expected[%0d]", d), sz > 0, 1'b1);
      if (sz > 0) begin
        if (d == 0) b = fr_q0.pop_front(); else b = fr_q1.pop_front();
        chk($sformatf("frame_data[%0d]", d), m_tdata[d], b.data);
        chk($sformatf("frame_last[%0d]", d), m_tlast[d], b.last);
      end
    end
    if (m_ts_tvalid[d] && m_ts_tready[d]) begin
      sz = (d == 0) ? ts_q0.size() : ts_q1.size();
      chk($sformatf("ts_expected[%0d]", d), sz > 0, 1'b1);
      if (sz > 0) begin
        if (d == 0) t = ts_q0.pop_front(); else t = ts_q1.pop_front();
        chk($sformatf("ts_data[%0d]", d), m_ts_tdata[d], t);
      end
    end
    if (err_pulse[d]) pulses[d]++;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic chk_drained(string tag);
    chk({tag, "_fr0"}, fr_q0.size(), 0);
    chk({tag, "_fr1"}, fr_q1.size(), 0);
    chk({tag, "_ts0"}, ts_q0.size(), 0);
    chk({tag, "_ts1"}, ts_q1.size(), 0);
  endtask

  logic [DW-1:0] fr_a [$];
  logic [DW-1:0] fr_b [$];
  logic [DW-1:0] tsb_a [9];
  logic [DW-1:0] tsb_b [9];

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_tdata[d] = '0; s_tvalid[d] = 1'b0; s_tlast[d] = 1'b0;
      len_tdata[d] = '0; len_tvalid[d] = 1'b0;
      m_tready[d] = 1'b1; m_ts_tready[d] = 1'b1;
      pulses[d] = 0; exp_err[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset", 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset", 1'b1);
    @(posedge clk); #1;

    // Directed example record in both timestamp positions
    fr_a = '{8'h11, 8'h12, 8'h13, 8'h14};
    for (int k = 0; k < 9; k++) tsb_a[k] = DW'(k + 1);
    good_record(0, fr_a, tsb_a);
    good_record(1, fr_a, tsb_a);
    idle(5);
    chk_drained("example");
    chk_errors("example");

    // FIFO full: five short records with the timestamp consumer stalled
    m_ts_tready[0] = 1'b0;
    for (int r = 0; r < 4; r++) rand_record(0, 2);
    fr_b = '{8'hA1, 8'hA2};
    for (int k = 0; k < 9; k++) tsb_b[k] = DW'(8'hB0 + k);
    fork
      good_record(0, fr_b, tsb_b);
    join_none
    repeat (40) @(negedge clk);
    chk("full_stall_tready", s_tready[0], 1'b0);
    chk("full_stall_tvalid", s_tvalid[0], 1'b1);
    chk("full_stall_on_final_beat", s_tdata[0], 8'hB8);
    chk("full_queued", ts_q0.size(), 5);
    chk("full_ts_tvalid", m_ts_tvalid[0], 1'b1);
    @(posedge clk); #1;
    m_ts_tready[0] = 1'b1;
    wait fork;
    idle(10);
    chk_drained("fifo_full");

    // Early tlast on frame beat index 2 of a declared 6-beat frame
    exp_beat(0, 8'h21, 1'b0);
    exp_beat(0, 8'h22, 1'b0);
    exp_beat(0, 8'h23, 1'b1);
    send_len(0, 16'd6);
    send_beat(0, 8'h21, 1'b0);
    send_beat(0, 8'h22, 1'b0);
    send_beat(0, 8'h23, 1'b1);
    exp_err[0]++;
    idle(3);
    chk_errors("early_tlast");
    rand_record(0, 3);

    // Missing tlast on the final timestamp beat, then junk drained
    exp_beat(0, 8'h31, 1'b0);
    exp_beat(0, 8'h32, 1'b1);
    exp_ts(0, 72'h484746454443424140);
    send_len(0, 16'd2);
    send_beat(0, 8'h31, 1'b0);
    send_beat(0, 8'h32, 1'b0);
    for (int k = 0; k < 9; k++) send_beat(0, DW'(8'h40 + k), 1'b0);
    for (int j = 0; j < 3; j++) send_beat(0, DW'(8'hE0 + j), j == 2);
    exp_err[0]++;
    idle(3);
    chk_errors("missing_tlast");

    // Zero length goes straight to drain
    send_len(0, 16'd0);
    send_beat(0, 8'hEE, 1'b1);
    exp_err[0]++;
    idle(3);
    chk_errors("zero_len");
    rand_record(0, 1);

    // Header mode: tlast during the timestamp header
    send_len(1, 16'd3);
    for (int k = 0; k < 4; k++) send_beat(1, DW'(8'h50 + k), k == 3);
    exp_err[1]++;
    idle(3);
    chk_errors("hdr_early_tlast");
    rand_record(1, 2);
    idle(5);
    chk_drained("directed_errors");

    // Random backpressure on both output streams and gaps on the input
    rand_bp = 1'b1;
    fork
      while (rand_bp) begin
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
          m_tready[d] = ($urandom_range(0, 3) != 0);
          m_ts_tready[d] = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    for (int r = 0; r < 200; r++) rand_record(0, $urandom_range(1, 8));
    for (int r = 0; r < 60; r++) rand_record(1, $urandom_range(1, 8));
    rand_bp = 1'b0;
    idle(3);
    for (int d = 0; d < 2; d++) begin m_tready[d] = 1'b1; m_ts_tready[d] = 1'b1; end
    idle(30);
    chk_drained("random");
    chk_errors("random");

    // Reset in the middle of a frame with a timestamp still held in the FIFO
    m_ts_tready[0] = 1'b0;
    rand_record(0, 3);
    exp_beat(0, 8'h61, 1'b0);
    exp_beat(0, 8'h62, 1'b0);
    send_len(0, 16'd6);
    send_beat(0, 8'h61, 1'b0);
    send_beat(0, 8'h62, 1'b0);
    chk("pre_reset_ts_pending", m_ts_tvalid[0], 1'b1);
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle_outputs("mid_reset", 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    ts_q0.delete();
    for (int d = 0; d < 2; d++) begin pulses[d] = 0; exp_err[d] = 0; end
    @(negedge clk);
    chk_idle_outputs("after_mid_reset", 1'b1);
    @(posedge clk); #1;
    m_ts_tready[0] = 1'b1;
    rand_record(0, 4);
    rand_record(1, 4);
    idle(10);
    chk_drained("after_reset");
    chk_errors("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
